// File: rtl/hps_rst_seq_ctrl.sv
// hps_rst_seq_ctrl
// Releases NUM_RST active-low domain resets one at a time, in ascending order.
// Each stage waits STAGE_DLY cycles before release, then waits for that
// domain's ack or a TIMEOUT. A software warm reset re-asserts every domain for
// HOLD_CYC cycles and restarts the sequence. In scan_mode the outputs follow
// ~rst directly, while the sequencer keeps running underneath.
module hps_rst_seq_ctrl #(
  parameter int NUM_RST   = 4,
  parameter int STAGE_DLY = 16,
  parameter int TIMEOUT   = 255,
  parameter int HOLD_CYC  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_mode,
  input  logic               sw_rst_req,
  input  logic [NUM_RST-1:0] rst_ack,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               busy,
  output logic               seq_done,
  output logic               seq_err
);

  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RST - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [7:0]       STAGE_CNT = 8'(STAGE_DLY);
  localparam logic [7:0]       TMO_CNT   = 8'(TIMEOUT);
  localparam logic [7:0]       HOLD_CNT  = 8'(HOLD_CYC);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_DLY      = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_DONE     = 3'd3,
    S_ASSERT   = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         cnt_r, cnt_s, cnt_dec_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [NUM_RST-1:0] rst_out_r, rst_out_s;
  logic               done_s, err_s;

  // Next-state and next-output logic; all registered values are decided here.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    rst_out_s = rst_out_r;
    done_s    = seq_done;
    err_s     = seq_err;
    // Saturating decrement: cnt never wraps below zero.
    if (cnt_r != 8'd0) begin
      cnt_dec_s = cnt_r - 8'd1;
    end else begin
      cnt_dec_s = cnt_r;
    end

    if (sw_rst_req && (state_r != S_ASSERT)) begin
      // Warm reset wins over every state; ASSERT itself cannot be re-armed.
      state_s   = S_ASSERT;
      rst_out_s = '0;
      done_s    = 1'b0;
      err_s     = 1'b0;
      idx_s     = '0;
      cnt_s     = HOLD_CNT;
    end else begin
      case (state_r)
        S_HOLD: begin
          state_s = S_DLY;
          cnt_s   = STAGE_CNT;
        end
        S_DLY: begin
          if (cnt_r == 8'd1) begin
            rst_out_s[idx_r] = 1'b1;
            cnt_s            = TMO_CNT;
            state_s          = S_WAIT_ACK;
          end else begin
            cnt_s = cnt_dec_s;
          end
        end
        S_WAIT_ACK: begin
          // A timeout advances exactly like an ack, but leaves a sticky error.
          if (rst_ack[idx_r] || (cnt_r == 8'd1)) begin
            if (!rst_ack[idx_r]) begin
              err_s = 1'b1;
            end else begin
              err_s = seq_err;
            end
            if (idx_r == LAST_IDX) begin
              state_s = S_DONE;
              done_s  = 1'b1;
            end else begin
              idx_s   = idx_r + IDX_ONE;
              cnt_s   = STAGE_CNT;
              state_s = S_DLY;
            end
          end else begin
            cnt_s = cnt_dec_s;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        S_ASSERT: begin
          if (cnt_r == 8'd1) begin
            state_s = S_DLY;
            cnt_s   = STAGE_CNT;
          end else begin
            cnt_s = cnt_dec_s;
          end
        end
        default: begin
          state_s   = S_HOLD;
          rst_out_s = '0;
          done_s    = 1'b0;
          idx_s     = '0;
          cnt_s     = 8'd0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_HOLD;
      cnt_r     <= 8'd0;
      idx_r     <= '0;
      rst_out_r <= '0;
      seq_done  <= 1'b0;
      busy      <= 1'b1;
      seq_err   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      rst_out_r <= rst_out_s;
      seq_done  <= done_s;
      busy      <= ~done_s;
      seq_err   <= err_s;
    end
  end

  // Scan bypass overrides only the reset outputs, without a clock.
  assign rst_out_n = scan_mode ? {NUM_RST{~rst}} : rst_out_r;

endmodule

// File: tb/tb_hps_rst_seq_ctrl.sv
// Directed bench for hps_rst_seq_ctrl with default parameters.
// A vector table covers the nominal release sequence; hand-written sequences
// cover timeout, warm reset, async reset, scan bypass and ack wiggle.
module tb_hps_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       scan_mode;
  logic       sw_rst_req;
  logic [3:0] rst_ack;
  logic [3:0] rst_out_n;
  logic       busy;
  logic       seq_done;
  logic       seq_err;

  int errors;
  int checks;
  int e;
  int b;

  typedef struct {
    int         n;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[9];

  hps_rst_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .scan_mode  (scan_mode),
    .sw_rst_req (sw_rst_req),
    .rst_ack    (rst_ack),
    .rst_out_n  (rst_out_n),
    .busy       (busy),
    .seq_done   (seq_done),
    .seq_err    (seq_err)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, e, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] o, input logic bz,
                         input logic dn, input logic er);
    chk({nm, ".out"},  rst_out_n, o);
    chk({nm, ".busy"}, {3'b000, busy},     {3'b000, bz});
    chk({nm, ".done"}, {3'b000, seq_done}, {3'b000, dn});
    chk({nm, ".err"},  {3'b000, seq_err},  {3'b000, er});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e = e + 1;
  endtask

  task automatic wait_to(input int n);
    while (e < n) tick();
  endtask

  // rst is released just after an edge, so the next edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    e   = 0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    e          = 0;
    rst        = 1'b1;
    scan_mode  = 1'b0;
    sw_rst_req = 1'b0;
    rst_ack    = 4'b1111;

    tbl[0] = '{16, 4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{17, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{33, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{34, 4'b0011, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{50, 4'b0011, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{51, 4'b0111, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{67, 4'b0111, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{68, 4'b1111, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{69, 4'b1111, 1'b0, 1'b1, 1'b0};

    // Reset state.
    tick();
    tick();
    chk_all("reset", 4'b0000, 1'b1, 1'b0, 1'b0);

    // Nominal sequence, all acks high.
    rst = 1'b0;
    e   = 0;
    for (int i = 0; i < 9; i++) begin
      wait_to(tbl[i].n);
      chk_all($sformatf("nominal[%0d]", i), tbl[i].out, tbl[i].busy, tbl[i].done, tbl[i].err);
    end

    // Stage 2 never acks: timeout after 255 cycles, sequence still completes.
    rst_ack = 4'b1011;
    do_reset();
    wait_to(305);
    chk_all("tmo_before", 4'b0111, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("tmo_hit", 4'b0111, 1'b1, 1'b0, 1'b1);
    wait_to(321);
    chk("tmo_s3_pre", rst_out_n, 4'b0111);
    tick();
    chk("tmo_s3_rel", rst_out_n, 4'b1111);
    tick();
    chk_all("tmo_done", 4'b1111, 1'b0, 1'b1, 1'b1);
    wait_to(330);
    chk_all("tmo_sticky", 4'b1111, 1'b0, 1'b1, 1'b1);

    // Warm reset from DONE clears everything including the sticky error.
    rst_ack    = 4'b1000;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    b = e;
    chk_all("warm_done", 4'b0000, 1'b1, 1'b0, 1'b0);
    // A second request inside the hold is ignored.
    wait_to(b + 2);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    // Ack wiggle on stage 0 while still in DLY.
    wait_to(b + 9);
    rst_ack[0] = 1'b1;
    wait_to(b + 12);
    rst_ack[0] = 1'b0;
    wait_to(b + 23);
    chk("hold_pre", rst_out_n, 4'b0000);
    tick();
    chk("hold_rel", rst_out_n, 4'b0001);
    wait_to(b + 34);
    rst_ack[0] = 1'b1;
    wait_to(b + 50);
    chk("wiggle_pre", rst_out_n, 4'b0001);
    tick();
    chk("wiggle_rel", rst_out_n, 4'b0011);

    // Warm reset during WAIT_ACK of stage 1.
    wait_to(b + 54);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk_all("warm_wait", 4'b0000, 1'b1, 1'b0, 1'b0);
    rst_ack = 4'b1111;
    wait_to(b + 78);
    chk("restart_pre", rst_out_n, 4'b0000);
    tick();
    chk("restart_s0", rst_out_n, 4'b0001);
    wait_to(b + 96);
    chk("restart_s1", rst_out_n, 4'b0011);

    // Async reset in DLY of stage 2, checked before any clock edge.
    wait_to(b + 100);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 1'b1, 1'b0, 1'b0);

    // Scan bypass follows ~rst combinationally.
    scan_mode = 1'b1;
    #1;
    chk("scan_rst1", rst_out_n, 4'b0000);
    rst = 1'b0;
    #1;
    chk("scan_rst0", rst_out_n, 4'b1111);
    rst = 1'b1;
    #1;
    chk("scan_rst1b", rst_out_n, 4'b0000);
    tick();
    rst = 1'b0;
    e   = 0;
    wait_to(20);
    chk("scan_run", rst_out_n, 4'b1111);
    scan_mode = 1'b0;
    #1;
    chk("scan_off", rst_out_n, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
